// File: rtl/vga_pkg.sv
// Shared constants for the VGA picture path.
//   H_VALID / V_VALID : active area of the 640x480 timing generator
//   ROM_AW            : word-address width of the picture ROM
//   COLOR_*           : RGB565 colour constants (white is the background default)
package vga_pkg;
   localparam int          H_VALID     = 640;
   localparam int          V_VALID     = 480;
   localparam int          ROM_AW      = 14;
   localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
   localparam logic [15:0] COLOR_BLACK = 16'h0000;
   localparam logic [15:0] COLOR_RED   = 16'hF800;
   localparam logic [15:0] COLOR_GREEN = 16'h07E0;
   localparam logic [15:0] COLOR_BLUE  = 16'h001F;
endpackage

// File: rtl/vga_pic_pos.sv
// Picture position generator: frame divider plus diagonal bounce.
//   vga_clk   : pixel clock
//   sys_rst_n : asynchronous active-low reset
//   frame_end : one-cycle pulse on the last active pixel of a frame
//   move_en   : 1 = motion enabled, 0 = divider and position frozen
//   x0, y0    : picture top-left corner, changes only the cycle after frame_end
module vga_pic_pos #(
   parameter int H_VALID   = vga_pkg::H_VALID,
   parameter int V_VALID   = vga_pkg::V_VALID,
   parameter int PIC_W     = 100,
   parameter int PIC_H     = 100,
   parameter int STEP      = 2,
   parameter int FRAME_DIV = 1
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic       frame_end,
   input  logic       move_en,
   output logic [9:0] x0,
   output logic [9:0] y0
);
   // Direction encoding: forward = right (x) / down (y)
   localparam logic [0:0] DIR_FWD  = 1'b1;
   localparam logic [0:0] DIR_REV  = 1'b0;

   localparam logic [9:0] X_MAX    = 10'(H_VALID - PIC_W);
   localparam logic [9:0] Y_MAX    = 10'(V_VALID - PIC_H);
   localparam logic [9:0] STEP_W   = 10'(STEP);
   localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

   logic [0:0]  dir_x;
   logic [0:0]  dir_y;
   logic [7:0]  div_cnt;
   logic [10:0] x_next;
   logic [10:0] y_next;

   // One axis of the bounce: returns {new_dir, new_pos}. The 11-bit compare
   // keeps pos+STEP from wrapping; reaching the limit clamps and reverses.
   function automatic logic [10:0] bounce(input logic [9:0] pos,
                                          input logic [0:0] dir,
                                          input logic [9:0] lim);
      logic [10:0] p;
      p = {1'b0, pos};
      if (dir == DIR_FWD) begin
         if (p + {1'b0, STEP_W} >= {1'b0, lim}) bounce = {DIR_REV, lim};
         else                                   bounce = {DIR_FWD, pos + STEP_W};
      end else begin
         if (pos <= STEP_W) bounce = {DIR_FWD, 10'd0};
         else               bounce = {DIR_REV, pos - STEP_W};
      end
   endfunction

   assign x_next = bounce(x0, dir_x, X_MAX);
   assign y_next = bounce(y0, dir_y, Y_MAX);

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x0      <= '0;
         y0      <= '0;
         dir_x   <= DIR_FWD;
         dir_y   <= DIR_FWD;
         div_cnt <= '0;
      end else if (frame_end && move_en) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt       <= '0;
            {dir_x, x0}   <= x_next;
            {dir_y, y0}   <= y_next;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
      end
   end
endmodule

// File: rtl/vga_pic_mover.sv
// Pixel source between the VGA timing generator and the picture ROM.
// Places a PIC_W x PIC_H RGB565 picture on a solid background and bounces it
// around the screen.
//   vga_clk    : pixel clock
//   sys_rst_n  : asynchronous active-low reset
//   pix_x/y    : requested pixel (10'h3FF = no request), one cycle early
//   move_en    : picture motion enable
//   rom_data   : ROM read data, one cycle after rom_rd_en
//   rom_rd_en  : ROM read strobe (combinational)
//   rom_addr   : ROM word address (combinational, 0 when no hit)
//   pix_data   : pixel colour, one cycle after pix_x/pix_y
module vga_pic_mover
   import vga_pkg::ROM_AW, vga_pkg::COLOR_WHITE;
#(
   parameter int          H_VALID   = vga_pkg::H_VALID,
   parameter int          V_VALID   = vga_pkg::V_VALID,
   parameter int          PIC_W     = 100,
   parameter int          PIC_H     = 100,
   parameter int          STEP      = 2,
   parameter int          FRAME_DIV = 1,
   parameter logic [15:0] BG_COLOR  = COLOR_WHITE
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic              move_en,
   input  logic [15:0]       rom_data,
   output logic              rom_rd_en,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [15:0]       pix_data
);
   logic [9:0]  x0;
   logic [9:0]  y0;
   logic        frame_end;
   logic        pic_hit;
   logic        pic_hit_d;
   logic [10:0] px;
   logic [10:0] py;
   logic [10:0] x0_w;
   logic [10:0] y0_w;
   logic [10:0] rel_x;
   logic [10:0] rel_y;

   vga_pic_pos #(
      .H_VALID   (H_VALID),
      .V_VALID   (V_VALID),
      .PIC_W     (PIC_W),
      .PIC_H     (PIC_H),
      .STEP      (STEP),
      .FRAME_DIV (FRAME_DIV)
   ) u_pos (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .frame_end (frame_end),
      .move_en   (move_en),
      .x0        (x0),
      .y0        (y0)
   );

   // Widen to 11 bits so x0+PIC_W cannot wrap; 3FF never falls inside.
   assign px    = {1'b0, pix_x};
   assign py    = {1'b0, pix_y};
   assign x0_w  = {1'b0, x0};
   assign y0_w  = {1'b0, y0};
   assign rel_x = px - x0_w;
   assign rel_y = py - y0_w;

   assign frame_end = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

   assign pic_hit = (px >= x0_w) && (px < x0_w + 11'(PIC_W)) &&
                    (py >= y0_w) && (py < y0_w + 11'(PIC_H));

   assign rom_rd_en = pic_hit;
   assign rom_addr  = pic_hit ? ROM_AW'(rel_y) * ROM_AW'(PIC_W) + ROM_AW'(rel_x)
                              : '0;

   // Stage boundary: ROM output register and hit flag advance together
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) pic_hit_d <= 1'b0;
      else            pic_hit_d <= pic_hit;
   end

   assign pix_data = pic_hit_d ? rom_data : BG_COLOR;
endmodule

// File: tb/tb_vga_pic_mover.sv
module tb_vga_pic_mover;
   localparam int          H     = 640;
   localparam int          V     = 480;
   localparam int          PW    = 100;
   localparam int          PH    = 100;
   localparam int          STEP  = 2;
   localparam int          FDIV  = 1;
   localparam int          XMAX  = H - PW;
   localparam int          YMAX  = V - PH;
   localparam logic [15:0] BG    = 16'hFFFF;

   logic        vga_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [9:0]  pix_x     = 10'h3FF;
   logic [9:0]  pix_y     = 10'h3FF;
   logic        move_en   = 1'b0;
   logic [15:0] rom_data;
   logic        rom_rd_en;
   logic [13:0] rom_addr;
   logic [15:0] pix_data;

   vga_pic_mover dut (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .move_en   (move_en),
      .rom_data  (rom_data),
      .rom_rd_en (rom_rd_en),
      .rom_addr  (rom_addr),
      .pix_data  (pix_data)
   );

   always #5 vga_clk = ~vga_clk;

   // Behavioural picture ROM with 1-cycle registered output; garbage when idle
   logic [15:0] rom_mem [0:16383];
   always @(posedge vga_clk) rom_data <= rom_rd_en ? rom_mem[rom_addr] : 16'($urandom);

   typedef struct { logic rd; logic [13:0] addr; string tag; } comb_t;
   typedef struct { logic [15:0] pix; string tag; } pix_t;
   comb_t comb_q[$];
   pix_t  pix_q[$];
   pix_t  pend;
   logic  pend_v = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: picture corner, direction (+1/-1) and frame count
   int mx, my, mdx, mdy, mcnt;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      mx = 0; my = 0; mdx = 1; mdy = 1; mcnt = 0;
   endfunction

   function automatic void axis_move(inout int p, inout int d, input int lim);
      if (d > 0) begin
         if (p + STEP >= lim) begin p = lim; d = -1; end
         else p = p + STEP;
      end else begin
         if (p <= STEP) begin p = 0; d = 1; end
         else p = p - STEP;
      end
   endfunction

   function automatic void model_frame();
      if (move_en) begin
         if (mcnt == FDIV - 1) begin
            mcnt = 0;
            axis_move(mx, mdx, XMAX);
            axis_move(my, mdy, YMAX);
         end else begin
            mcnt++;
         end
      end
   endfunction

   // Monitor: combinational outputs of this cycle and pix_data for last cycle
   always @(negedge vga_clk) begin
      comb_t c;
      pix_t  p;
      if (sys_rst_n) begin
         if (comb_q.size() > 0) begin
            c = comb_q.pop_front();
            check({c.tag, " rom_rd_en"}, int'(rom_rd_en), int'(c.rd));
            check({c.tag, " rom_addr"},  int'(rom_addr),  int'(c.addr));
         end
         if (pix_q.size() > 0) begin
            p = pix_q.pop_front();
            check({p.tag, " pix_data"}, int'(pix_data), int'(p.pix));
         end
      end
   end

   // Issue one request per cycle; expectations go to the scoreboard queues
   task automatic req(input int x, input int y, input string tag);
      logic hit;
      int   a;
      @(posedge vga_clk);
      #1;
      if (pend_v) pix_q.push_back(pend);
      pix_x = 10'(x);
      pix_y = 10'(y);
      hit = (x >= mx) && (x < mx + PW) && (y >= my) && (y < my + PH);
      a   = hit ? (y - my) * PW + (x - mx) : 0;
      comb_q.push_back('{rd: hit, addr: 14'(a), tag: tag});
      pend.pix = hit ? rom_mem[a] : BG;
      pend.tag = tag;
      pend_v   = 1'b1;
      if (x == H - 1 && y == V - 1) model_frame();
   endtask

   task automatic frame(input int nreq);
      int x, y;
      for (int i = 0; i < nreq; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            x = $urandom_range(0, H - 1);
            y = $urandom_range(0, V - 1);
         end else begin
            x = mx - 5 + $urandom_range(0, PW + 10);
            y = my - 5 + $urandom_range(0, PH + 10);
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            if (x > H - 1) x = H - 1;
            if (y > V - 1) y = V - 1;
         end
         if (x == H - 1 && y == V - 1) y = V - 2;
         req(x, y, "pix");
      end
      req(H - 1, V - 1, "frame_end");
      req(1023, 1023, "idle");
      check("x0 model", int'(dut.x0), mx);
      check("y0 model", int'(dut.y0), my);
      check("x0 range", int'(dut.x0 <= 10'(XMAX)), 1);
      check("y0 range", int'(dut.y0 <= 10'(YMAX)), 1);
   endtask

   initial begin
      int sx, sy, prev_x, prev_y;
      int saw_x, saw_y;
      for (int i = 0; i < 16384; i++) rom_mem[i] = 16'($urandom);
      rom_mem[0] = 16'h1234;
      model_reset();

      // Reset state
      repeat (3) @(posedge vga_clk);
      #1;
      check("reset rom_rd_en", int'(rom_rd_en), 0);
      check("reset rom_addr",  int'(rom_addr),  0);
      check("reset pix_data",  int'(pix_data),  int'(BG));
      #2 sys_rst_n = 1'b1;
      pend = '{pix: BG, tag: "post_reset"};
      pend_v = 1'b1;

      // Origin read and edges of the picture at (0,0)
      req(0, 0, "origin");
      req(99, 99, "last_pixel");
      req(100, 99, "right_of_pic");
      req(0, 100, "below_pic");
      req(1023, 1023, "idle");

      // One frame step
      move_en = 1'b1;
      frame(0);
      check("first step x0", int'(dut.x0), 2);
      check("first step y0", int'(dut.y0), 2);
      req(2, 2, "moved_origin");
      req(1, 2, "left_of_moved");
      req(1023, 1023, "idle");

      // Long random run through both bounces
      saw_x = 0; saw_y = 0;
      prev_x = int'(dut.x0); prev_y = int'(dut.y0);
      for (int f = 0; f < 600; f++) begin
         frame($urandom_range(0, 3));
         if (prev_x == XMAX && saw_x == 0) begin
            check("x bounce", int'(dut.x0), XMAX - STEP);
            saw_x = 1;
         end
         if (prev_y == YMAX && saw_y == 0) begin
            check("y bounce", int'(dut.y0), YMAX - STEP);
            saw_y = 1;
         end
         prev_x = int'(dut.x0);
         prev_y = int'(dut.y0);
      end
      check("x reached max", saw_x, 1);
      check("y reached max", saw_y, 1);

      // Freeze
      move_en = 1'b0;
      sx = int'(dut.x0);
      sy = int'(dut.y0);
      for (int f = 0; f < 3; f++) frame(2);
      check("freeze x0", int'(dut.x0), sx);
      check("freeze y0", int'(dut.y0), sy);

      // Reset in the middle of a line while the picture is being read
      move_en = 1'b1;
      req(mx + 5, my + 5, "pre_reset_a");
      req(mx + 6, my + 5, "pre_reset_b");
      #3 sys_rst_n = 1'b0;
      #1;
      check("mid reset pix_data", int'(pix_data), int'(BG));
      check("mid reset x0", int'(dut.x0), 0);
      check("mid reset y0", int'(dut.y0), 0);
      comb_q.delete();
      pix_q.delete();
      model_reset();
      pix_x = 10'h3FF;
      pix_y = 10'h3FF;
      @(posedge vga_clk);
      #3 sys_rst_n = 1'b1;
      pend = '{pix: BG, tag: "post_mid_reset"};
      pend_v = 1'b1;
      req(0, 0, "after_reset");
      req(1023, 1023, "idle");
      req(1023, 1023, "idle");
      @(negedge vga_clk);
      #1;
      check("queues drained", comb_q.size() + pix_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
